// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcodes, immediate formats and the
// ID/EX control bundle used by the decode stage and the execute-stage ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SRA  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_LINK = 5'd5;
    localparam logic [4:0] ALU_LUI  = 5'd6;
    localparam logic [4:0] ALU_BGE  = 5'd7;
    localparam logic [4:0] ALU_BNE  = 5'd8;
    localparam logic [4:0] ALU_OR   = 5'd9;
    localparam logic [4:0] ALU_AND  = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SLT  = 5'd12;
    localparam logic [4:0] ALU_SLTU = 5'd13;
    localparam logic [4:0] ALU_BEQ  = 5'd14;
    localparam logic [4:0] ALU_BLT  = 5'd15;
    localparam logic [4:0] ALU_BLTU = 5'd16;
    localparam logic [4:0] ALU_BGEU = 5'd17;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic       op1_sel;
        logic       op2_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    // Integer ALU code shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [4:0] arith_code(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  arith_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_code = ALU_SLL;
            3'b010:  arith_code = ALU_SLT;
            3'b011:  arith_code = ALU_SLTU;
            3'b100:  arith_code = ALU_XOR;
            3'b101:  arith_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_code = ALU_OR;
            default: arith_code = ALU_AND;
        endcase
    endfunction

    function automatic ctrl_t kill_enables(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.branch    = 1'b0;
        r.jump      = 1'b0;
        r.jalr      = 1'b0;
        r.illegal   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of an RV32I
// instruction word for the format chosen by the decoder.
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  imm_type_i,
    output logic [31:0] imm_o
);

    always_comb begin
        case (imm_type_e'(imm_type_i))
            IMM_I:     imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_SHAMT: imm_o = {27'd0, instr_i[24:20]};
            IMM_S:     imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm_o = {instr_i[31:12], 12'd0};
            IMM_J:     imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default:   imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_alu_decode.sv
// RV32I decode stage: turns an instruction word into ALU control, operand
// selects and immediates, and owns the ID/EX register with stall/flush.
module id_alu_decode
    import alu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            instr_valid_i,
    output logic            ready_o,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [4:0]      alu_ctrl_o,
    output logic            op1_sel_o,
    output logic            op2_sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [2:0]      mem_funct3_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            jalr_o,
    output logic            illegal_o
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    ctrl_t      ctrl_d, ctrl_q;
    imm_type_e  imm_type;
    logic [2:0] mem_funct3_d, mem_funct3_q;
    logic [XLEN-1:0] imm_d, imm_q, pc_q;
    logic [4:0] rs1_q, rs2_q, rd_q;
    logic       valid_q, illegal, accept;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_d       = '0;
        imm_type     = IMM_NONE;
        mem_funct3_d = 3'd0;
        illegal      = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                ctrl_d.op2_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_type         = IMM_I;
                ctrl_d.alu_ctrl  = arith_code(funct3, funct7 == F7_ALT);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_type = IMM_SHAMT;
                    illegal  = !(funct7 == F7_BASE || (funct3 == 3'b101 && funct7 == F7_ALT));
                end else begin
                    ctrl_d.alu_ctrl = arith_code(funct3, 1'b0);
                end
            end
            OPC_OP: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = arith_code(funct3, funct7 == F7_ALT);
                illegal = !(funct7 == F7_BASE ||
                            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_LUI: begin
                ctrl_d.alu_ctrl  = ALU_LUI;
                ctrl_d.op2_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_type         = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_d.op1_sel   = 1'b1;
                ctrl_d.op2_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_type         = IMM_U;
            end
            OPC_JAL: begin
                ctrl_d.alu_ctrl  = ALU_LINK;
                ctrl_d.op1_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jump      = 1'b1;
                imm_type         = IMM_J;
            end
            OPC_JALR: begin
                ctrl_d.alu_ctrl  = ALU_LINK;
                ctrl_d.op1_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.jalr      = 1'b1;
                imm_type         = IMM_I;
                illegal          = funct3 != 3'b000;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1;
                imm_type      = IMM_B;
                case (funct3)
                    3'b000:  ctrl_d.alu_ctrl = ALU_BEQ;
                    3'b001:  ctrl_d.alu_ctrl = ALU_BNE;
                    3'b100:  ctrl_d.alu_ctrl = ALU_BLT;
                    3'b101:  ctrl_d.alu_ctrl = ALU_BGE;
                    3'b110:  ctrl_d.alu_ctrl = ALU_BLTU;
                    3'b111:  ctrl_d.alu_ctrl = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_d.op2_sel   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_read  = 1'b1;
                mem_funct3_d     = funct3;
                imm_type         = IMM_I;
                illegal          = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
            end
            OPC_STORE: begin
                ctrl_d.op2_sel   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                mem_funct3_d     = funct3;
                imm_type         = IMM_S;
                illegal          = funct3[2] || funct3 == 3'b011;
            end
            default: illegal = 1'b1;
        endcase

        if (instr_i[11:7] == 5'd0)
            ctrl_d.reg_write = 1'b0;
        // Illegal encodings travel downstream as a trap marker with nothing else enabled.
        if (illegal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            imm_type       = IMM_NONE;
            mem_funct3_d   = 3'd0;
        end
    end

    imm_gen u_imm_gen (
        .instr_i    (instr_i),
        .imm_type_i (imm_type),
        .imm_o      (imm_d)
    );

    assign ready_o = !valid_q || !stall_i;
    assign accept  = instr_valid_i && ready_o;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            imm_q        <= '0;
            pc_q         <= RESET_PC;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            mem_funct3_q <= 3'd0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= kill_enables(ctrl_q);
        end else if (!(stall_i && valid_q)) begin
            if (accept) begin
                valid_q      <= 1'b1;
                ctrl_q       <= ctrl_d;
                imm_q        <= imm_d;
                pc_q         <= pc_i;
                rs1_q        <= instr_i[19:15];
                rs2_q        <= instr_i[24:20];
                rd_q         <= instr_i[11:7];
                mem_funct3_q <= mem_funct3_d;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= kill_enables(ctrl_q);
            end
        end
    end

    assign valid_o      = valid_q;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign op1_sel_o    = ctrl_q.op1_sel;
    assign op2_sel_o    = ctrl_q.op2_sel;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign jalr_o       = ctrl_q.jalr;
    assign illegal_o    = ctrl_q.illegal;
    assign imm_o        = imm_q;
    assign pc_o         = pc_q;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign mem_funct3_o = mem_funct3_q;

endmodule

// File: doc/id_alu_decode.md
Name: id_alu_decode

Overview:
Decode stage that produces the 5-bit ALU operation code and operand selects consumed by the execute-stage ALU, from a fetched RV32I instruction word. Sits between the IF/ID and EX stages of the CPU and owns the ID/EX pipeline register for ALU control, immediates and memory/writeback control. It supports a valid/ready handshake with fetch, a stall from execute, and a flush from branch/jump resolution.

Parameters:
XLEN, 32, datapath width of the PC and immediate (fixed at 32; kept for symmetry)
RESET_PC, 32'h0000_0000, value of pc_o after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
instr_i  in  32  instruction word from fetch
pc_i  in  32  PC of instr_i
instr_valid_i  in  1  instr_i/pc_i valid this cycle
ready_o  out  1  decode accepts instr_i this cycle
stall_i  in  1  execute cannot accept; hold ID/EX register
flush_i  in  1  kill ID/EX contents (taken branch/jump)
valid_o  out  1  ID/EX register holds a live instruction
alu_ctrl_o  out  5  ALU operation code (ALU_* constants)
op1_sel_o  out  1  0 = rs1 data, 1 = pc_o
op2_sel_o  out  1  0 = rs2 data, 1 = imm_o
imm_o  out  32  sign-extended immediate (I/S/B/U/J per opcode)
pc_o  out  32  PC of the held instruction
rs1_o, rs2_o, rd_o  out  5 each  register indices
reg_write_o  out  1  writeback enable (forced 0 when rd = x0)
mem_read_o, mem_write_o  out  1 each  load/store
mem_funct3_o  out  3  load/store width field
branch_o, jump_o, jalr_o  out  1 each  control-transfer class
illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (rst_i=1 at clock edge): valid_o=0, pc_o=RESET_PC, all other outputs 0 (alu_ctrl_o=ALU_ADD=0). Reset mid-stall/flush discards everything.
- ready_o = !valid_o || !stall_i (combinational); a bubble is overwritten even while stalled.
- Accept = instr_valid_i && ready_o. Latency 1 cycle: decoded fields appear on outputs the edge after acceptance.
- Priority per edge: rst_i > flush_i > stall_i > load. flush_i: valid_o<=0 and all enables (reg_write, mem_*, branch, jump, jalr, illegal) <=0, even if stall_i=1 or accept=1 (the accepted instruction is dropped). stall_i && valid_o: all outputs hold. No accept and no stall: valid_o<=0, enables <=0.
- When valid_o=0, all enables are 0 (outputs are a safe bubble).
- Decode table (opcode / funct3 / funct7 -> alu_ctrl, selects):
  OP-IMM 0010011: 000->0 ADD, 001 (f7=0)->1 SLL, 101 f7=0->11 SRL, f7=0100000->2 SRA, 100->4 XOR, 110->9 OR, 111->10 AND, 010->12 SLT, 011->13 SLTU; op2_sel=1, I-imm; shift imm is shamt, other f7 illegal.
  OP 0110011: same mapping, 000 f7=0100000->3 SUB; op2_sel=0; f7 not 0/0100000 (or 0100000 on non-add/shift) illegal.
  LUI 0110111->6, op2_sel=1, U-imm. AUIPC 0010111->0, op1_sel=1, op2_sel=1.
  JAL 1101111->5, op1_sel=1, J-imm, jump_o. JALR 1100111 f3=000->5, op1_sel=1, I-imm, jump_o, jalr_o (target computed outside ALU).
  BRANCH 1100011: 000->14 BEQ, 001->8 BNE, 100->15 BLT, 101->7 BGE, 110->16 BLTU, 111->17 BGEU; op2_sel=0, B-imm, branch_o, reg_write=0; 010/011 illegal.
  LOAD 0000011 f3 in {000,001,010,100,101}->0, op2_sel=1, I-imm, mem_read. STORE 0100011 f3 in {000,001,010}->0, S-imm, mem_write, reg_write=0.
- Illegal: illegal_o=1, alu_ctrl_o=0, every other enable 0, valid_o=1 (trap handled downstream).
- Immediates: sign-extended from bit 31; B/J LSB = 0; U = instr[31:12]<<12.

Decomposition:
- Shared package alu_pkg: ALU_* code constants 0..17 (replacing literal codes in the ALU), OPC_* opcode constants, immediate-type enum.
- One combinational sub-module imm_gen (instr, type -> 32-bit imm); everything else stays in id_alu_decode.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) accepted -> next cycle valid_o=1, alu_ctrl_o=0, op2_sel_o=1, imm_o=0xFFFFFFFF, rd_o=1, reg_write_o=1.
- sub x3,x4,x5 (0x405201B3) then sra x3,x4,x5 (0x405251B3) -> alu_ctrl_o=3 then 2; funct7=0x01 on add -> illegal_o=1, reg_write_o=0.
- Each branch funct3 000/001/100/101/110/111 -> 14/8/15/7/16/17, branch_o=1, reg_write_o=0; bltu with offset -4096 -> imm_o=0xFFFFF000.
- Stall: stall_i=1 for 3 cycles with valid_o=1 -> ready_o=0, outputs frozen; stall_i drop -> next instruction loads in one cycle.
- Flush with stall_i=1 and instr_valid_i=1 same cycle -> valid_o=0, all enables 0 next cycle; addi x0,x0,0 -> reg_write_o=0.
- Reset asserted mid-stream -> next edge valid_o=0, pc_o=RESET_PC, alu_ctrl_o=0; lui x7,0x12345 after release -> alu_ctrl_o=6, imm_o=0x12345000.
